// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//   Valid/ready streaming bus carried between pipe_stage_reg and its
//   neighbours. One instance models one link of the pipeline.
//
//   Signals
//     Valid : producer has a payload on Data this cycle
//     Ready : consumer can take the payload this cycle
//     Data  : payload, WIDTH bits
//
//   Modports
//     master : producer side (drives Valid/Data, observes Ready)
//     slave  : consumer side (observes Valid/Data, drives Ready)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Valid;
    logic             Ready;
    logic [WIDTH-1:0] Data;

    modport master (output Valid, output Data, input Ready);
    modport slave  (input Valid, input Data, output Ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Registered valid/ready pipeline stage with one cycle of latency.
//   Out_Data/Out_Valid always come straight from flops; payloads leave in
//   acceptance order.
//
//   Build option
//     PIPE_STAGE_SKID_EN defined   : a second (skid) entry is present.
//                                    In_Ready is a flop equal to
//                                    NOT(skid valid), so no combinational
//                                    path exists from Out_Ready to In_Ready
//                                    and full throughput is sustained.
//     PIPE_STAGE_SKID_EN undefined : single entry only; In_Ready is
//                                    (NOT Out_Valid) OR Out_Ready.
//
//   Parameters
//     WIDTH       : payload width (1..256)
//     RESET_VALUE : Out_Data value after Reset or Flush
//
//   Ports
//     Clk       : clock, rising edge
//     Reset     : synchronous, active-high; wins over Flush
//     Flush     : synchronous; drops all held entries and any same-cycle
//                 input transfer
//     inBus     : upstream link (slave): In_Valid / In_Ready / In_Data
//     outBus    : downstream link (master): Out_Valid / Out_Ready / Out_Data
//     Occupancy : registered count of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    pipe_stage_reg_if.slave   inBus,
    pipe_stage_reg_if.master  outBus,
    output logic [1:0]        Occupancy
);

    // Source selected for the main entry at the next edge.
    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_IN,
        SEL_SKID
    } mainSel_t;

    logic             mainVld_p0;
    logic [WIDTH-1:0] mainData_p0;
    logic             mainVldNxt;
    mainSel_t         mainSel;
    logic             inXfer;
    logic             outXfer;
    logic             clearAll;

    assign clearAll      = Reset || Flush;
    assign outBus.Valid  = mainVld_p0;
    assign outBus.Data   = mainData_p0;
    assign outXfer       = mainVld_p0 && outBus.Ready;

`ifdef PIPE_STAGE_SKID_EN

    logic             skidVld_p0;
    logic [WIDTH-1:0] skidData_p0;
    logic             inReady_p0;
    logic             skidVldNxt;
    logic             skidLoad;

    assign inBus.Ready = inReady_p0;
    assign inXfer      = inBus.Valid && inReady_p0;

    // While the skid entry is valid In_Ready is low, so an output transfer
    // refilling main from skid never coincides with an input transfer.
    always_comb begin
        mainVldNxt = mainVld_p0;
        skidVldNxt = skidVld_p0;
        mainSel    = SEL_HOLD;
        skidLoad   = 1'b0;
        if (outXfer) begin
            if (skidVld_p0) begin
                mainSel    = SEL_SKID;
                skidVldNxt = 1'b0;
            end else if (inXfer) begin
                mainSel    = SEL_IN;
            end else begin
                mainVldNxt = 1'b0;
            end
        end else if (inXfer) begin
            if (!mainVld_p0) begin
                mainSel    = SEL_IN;
                mainVldNxt = 1'b1;
            end else begin
                skidLoad   = 1'b1;
                skidVldNxt = 1'b1;
            end
        end
    end

    // Control registers
    always_ff @(posedge Clk) begin
        if (clearAll) begin
            mainVld_p0 <= 1'b0;
            skidVld_p0 <= 1'b0;
            inReady_p0 <= 1'b1;
            Occupancy  <= 2'd0;
        end else begin
            mainVld_p0 <= mainVldNxt;
            skidVld_p0 <= skidVldNxt;
            inReady_p0 <= !skidVldNxt;
            Occupancy  <= {1'b0, mainVldNxt} + {1'b0, skidVldNxt};
        end
    end

    // Skid payload: its content is meaningless while skidVld_p0 is low.
    always_ff @(posedge Clk) begin
        if (skidLoad) begin
            skidData_p0 <= inBus.Data;
        end
    end

    // Main payload: Out_Data must show RESET_VALUE after Reset/Flush.
    always_ff @(posedge Clk) begin
        if (clearAll) begin
            mainData_p0 <= RESET_VALUE;
        end else begin
            case (mainSel)
                SEL_IN:   mainData_p0 <= inBus.Data;
                SEL_SKID: mainData_p0 <= skidData_p0;
                default:  mainData_p0 <= mainData_p0;
            endcase
        end
    end

`else

    // Single entry: accept when empty or when the held payload leaves now.
    assign inBus.Ready = !mainVld_p0 || outBus.Ready;
    assign inXfer      = inBus.Valid && inBus.Ready;

    always_comb begin
        mainVldNxt = mainVld_p0;
        mainSel    = SEL_HOLD;
        if (inXfer) begin
            mainSel    = SEL_IN;
            mainVldNxt = 1'b1;
        end else if (outXfer) begin
            mainVldNxt = 1'b0;
        end
    end

    // Control registers
    always_ff @(posedge Clk) begin
        if (clearAll) begin
            mainVld_p0 <= 1'b0;
            Occupancy  <= 2'd0;
        end else begin
            mainVld_p0 <= mainVldNxt;
            Occupancy  <= {1'b0, mainVldNxt};
        end
    end

    // Main payload: Out_Data must show RESET_VALUE after Reset/Flush.
    always_ff @(posedge Clk) begin
        if (clearAll) begin
            mainData_p0 <= RESET_VALUE;
        end else if (mainSel == SEL_IN) begin
            mainData_p0 <= inBus.Data;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Self-checking bench for pipe_stage_reg (WIDTH=16, RESET_VALUE=0xDEAD).
//   The reference model is a FIFO queue of accepted payloads whose capacity
//   is the configured depth; every cycle the DUT outputs are compared with
//   the head and size of that queue. Directed sequences are followed by a
//   randomized phase with occasional Flush and Reset.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int unsigned WIDTH = 16;
    localparam logic [15:0] RVAL  = 16'hDEAD;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Flush;
    logic [1:0] Occupancy;

    pipe_stage_reg_if #(.WIDTH(WIDTH)) inIf ();
    pipe_stage_reg_if #(.WIDTH(WIDTH)) outIf ();

    pipe_stage_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RVAL)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Flush     (Flush),
        .inBus     (inIf),
        .outBus    (outIf),
        .Occupancy (Occupancy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] q[$];
    bit          modelValid = 0;
    bit          dataKnown  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check In_Ready before the edge, advance the
    // model across the edge and compare the outputs after it.
    task automatic step(input logic v, input logic [15:0] d, input logic r,
                        input logic fl, input logic rs);
        logic expReady;
        bit   inX;
        bit   outX;
        inIf.Valid  = v;
        inIf.Data   = d;
        outIf.Ready = r;
        Flush       = fl;
        Reset       = rs;
        #1;
        if (DEPTH == 2) expReady = (q.size() < 2);
        else            expReady = (q.size() == 0) || r;
        if (modelValid) checkVal("in_ready", {31'd0, inIf.Ready}, {31'd0, expReady});
        inX  = modelValid && v && expReady;
        outX = (q.size() > 0) && r;
        @(posedge Clk);
        #1;
        if (rs) modelValid = 1;
        if (rs || fl) begin
            if (modelValid) begin
                q.delete();
                dataKnown = 1;
            end
        end else if (modelValid) begin
            if (outX) void'(q.pop_front());
            if (inX)  q.push_back(d);
            if (outX && q.size() == 0) dataKnown = 0;
        end
        if (modelValid) begin
            checkVal("out_valid", {31'd0, outIf.Valid}, {31'd0, q.size() > 0});
            checkVal("occupancy", {30'd0, Occupancy}, q.size());
            if (q.size() > 0)   checkVal("out_data", {16'd0, outIf.Data}, {16'd0, q[0]});
            else if (dataKnown) checkVal("out_data_rst", {16'd0, outIf.Data}, {16'd0, RVAL});
        end
    endtask

    initial begin
        inIf.Valid  = 1'b0;
        inIf.Data   = '0;
        outIf.Ready = 1'b0;
        Flush       = 1'b0;
        Reset       = 1'b1;

        // Reset state
        step(0, 16'h0, 0, 0, 1);
        step(0, 16'h0, 0, 0, 1);
        checkVal("rst_data", {16'd0, outIf.Data}, {16'd0, RVAL});
        checkVal("rst_ready", {31'd0, inIf.Ready}, 32'd1);

        // Single payload, one cycle latency
        step(1, 16'h0011, 1, 0, 0);
        checkVal("lat1_valid", {31'd0, outIf.Valid}, 32'd1);
        checkVal("lat1_data", {16'd0, outIf.Data}, 32'h11);
        checkVal("lat1_occ", {30'd0, Occupancy}, 32'd1);
        step(0, 16'h0, 1, 0, 0);

        // Back-to-back stream, no bubbles
        for (int i = 1; i <= 8; i++) begin
            step(1, 16'(i), 1, 0, 0);
            checkVal("stream_data", {16'd0, outIf.Data}, i);
            checkVal("stream_occ", {30'd0, Occupancy}, 32'd1);
        end
        step(0, 16'h0, 1, 0, 0);

`ifdef PIPE_STAGE_SKID_EN
        // Stall fills the skid entry, then drain in order
        step(1, 16'h00A0, 0, 0, 0);
        step(1, 16'h00A1, 0, 0, 0);
        checkVal("skid_occ", {30'd0, Occupancy}, 32'd2);
        checkVal("skid_ready", {31'd0, inIf.Ready}, 32'd0);
        checkVal("skid_hold", {16'd0, outIf.Data}, 32'hA0);
        step(0, 16'h0, 1, 0, 0);
        checkVal("skid_drain1", {16'd0, outIf.Data}, 32'hA1);
        step(0, 16'h0, 1, 0, 0);
        checkVal("skid_drain2", {31'd0, outIf.Valid}, 32'd0);
`else
        // In_Ready follows Out_Ready combinationally while holding
        step(1, 16'h00B0, 0, 0, 0);
        outIf.Ready = 1'b0;
        #1;
        checkVal("comb_ready_lo", {31'd0, inIf.Ready}, 32'd0);
        outIf.Ready = 1'b1;
        #1;
        checkVal("comb_ready_hi", {31'd0, inIf.Ready}, 32'd1);
        step(0, 16'h0, 1, 0, 0);
`endif

        // Flush with full stage and a same-cycle input
        for (int i = 0; i < DEPTH; i++) step(1, 16'(16'hC0 + i), 0, 0, 0);
        checkVal("pre_flush_occ", {30'd0, Occupancy}, DEPTH);
        step(1, 16'h0055, 0, 1, 0);
        checkVal("flush_valid", {31'd0, outIf.Valid}, 32'd0);
        checkVal("flush_data", {16'd0, outIf.Data}, {16'd0, RVAL});
        step(0, 16'h0, 1, 0, 0);
        checkVal("flush_no55", {31'd0, outIf.Valid}, 32'd0);

        // Reset and Flush together with an input
        step(1, 16'h0066, 0, 0, 0);
        step(1, 16'h0077, 1, 1, 1);
        checkVal("rstfl_data", {16'd0, outIf.Data}, 32'hDEAD);
        checkVal("rstfl_occ", {30'd0, Occupancy}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic v;
            logic r;
            logic fl;
            logic rs;
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 40) == 0);
            rs = ($urandom_range(0, 150) == 0);
            step(v, 16'($urandom), r, fl, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter RESET_VALUE, default 0: payload value loaded on reset or flush, WIDTH bits wide.
REQ-003 Clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Reset  input  1: reset, synchronous and active-high.
REQ-005 Flush  input  1: synchronous flush; discards all held entries.
REQ-006 In_Valid  input  1: upstream has a payload on In_Data.
REQ-007 In_Ready  output  1: the stage can accept a payload this cycle.
REQ-008 In_Data  input  WIDTH: upstream payload.
REQ-009 Out_Valid  output  1: Out_Data holds a valid payload.
REQ-010 Out_Ready  input  1: downstream accepts the payload this cycle.
REQ-011 Out_Data  output  WIDTH: registered payload to downstream.
REQ-012 Occupancy  output  2: count of held entries (0..2), registered.

Function
REQ-013 An input transfer SHALL occur on a cycle where In_Valid and In_Ready are both 1; an output transfer SHALL occur on a cycle where Out_Valid and Out_Ready are both 1.
REQ-014 The stage SHALL hold a main entry (drives Out_Data/Out_Valid) and, when configured, one skid entry.
REQ-015 Latency SHALL be 1 cycle: a payload accepted into an empty stage at edge N appears on Out_Data with Out_Valid=1 after edge N.
REQ-016 When Out_Valid=1 and Out_Ready=0, Out_Data and Out_Valid SHALL stay stable until an output transfer or flush.
REQ-017 Payloads SHALL leave in acceptance order; none SHALL be dropped or duplicated except by Flush/Reset.
REQ-018 On an output transfer, the main entry SHALL load the skid entry if one is valid, else the same-cycle input, else become empty.
REQ-019 A simultaneous input and output transfer with no skid entry SHALL leave Occupancy unchanged and load the new payload into the main entry.
REQ-020 An input transfer while the main entry is full and not draining SHALL go into the skid entry; Occupancy becomes 2.
REQ-021 Occupancy SHALL equal the number of valid entries after each edge and never exceed the configured depth.
REQ-022 Flush=1 SHALL, at the next edge, clear all entries, set Out_Valid=0 and Occupancy=0, load Out_Data with RESET_VALUE, and discard any same-cycle input transfer.
REQ-023 Reset SHALL take priority over Flush; Flush SHALL take priority over all transfers.
REQ-024 Out_Data SHALL be driven only from registers, never combinationally from In_Data.

Reset
REQ-025 On Reset=1 at a rising edge: Out_Valid=0, Out_Data=RESET_VALUE, skid entry invalid, Occupancy=0; In_Ready=1 in the following cycle.
REQ-026 Reset asserted mid-transfer SHALL discard all held and in-flight payloads; no transfer is honoured on that edge.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined: the skid entry exists; In_Ready SHALL be a register equal to NOT(skid valid), with no combinational path from Out_Ready; full throughput is sustained; Occupancy reaches 2.
REQ-028 Macro PIPE_STAGE_SKID_EN undefined: no skid entry; In_Ready SHALL equal (NOT Out_Valid) OR Out_Ready, combinationally; Occupancy never exceeds 1; all other requirements unchanged.

Verification
REQ-029 Reset, then In_Valid=1, In_Data=0x11, Out_Ready=1 for one cycle -> next cycle Out_Valid=1, Out_Data=0x11, Occupancy=1.
REQ-030 Stream 0x01..0x08 back-to-back with Out_Ready=1 -> outputs 0x01..0x08 in consecutive cycles, no bubbles, Occupancy stays 1.
REQ-031 (SKID_EN) Out_Ready=0 while sending 0xA0 then 0xA1 -> Occupancy=2, In_Ready=0, Out_Data=0xA0 held; Out_Ready=1 -> 0xA0 then 0xA1 delivered in consecutive cycles.
REQ-032 (no SKID_EN) Out_Ready=0 with Out_Valid=1 -> In_Ready=0 in the same cycle; raise Out_Ready -> In_Ready=1 in the same cycle.
REQ-033 Occupancy=2, Flush=1 with In_Valid=1, In_Data=0x55 -> next cycle Out_Valid=0, Occupancy=0, Out_Data=RESET_VALUE, 0x55 never appears.
REQ-034 Reset and Flush both asserted with In_Valid=1 -> reset values next cycle; with RESET_VALUE=0xDEAD, Out_Data=0xDEAD.
